// File: rtl/eth_frame_tx_pkg.sv
// Shared types and constants for the Ethernet transmit framer.
package eth_frame_tx_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int ETH_MIN_FRAME   = 60;
  localparam int ETH_MAX_PAYLOAD = 1500;

  typedef enum logic [2:0] {IDLE, HDR, PAY, PAD, LAST} tx_state_t;

  // Unused low-order byte lanes of a beat carrying nbytes (1..4) bytes.
  function automatic logic [1:0] beat_empty(input logic [2:0] nbytes);
    return 2'(3'd4 - nbytes);
  endfunction

endpackage

// File: rtl/eth_frame_tx_if.sv
// Descriptor, payload and Avalon-ST transmit signals of the framer.
interface eth_frame_tx_if;
  import eth_frame_tx_pkg::*;

  logic        hdr_valid;
  logic        hdr_ready;
  mac_addr_t   hdr_dst;
  mac_addr_t   hdr_src;
  logic [15:0] hdr_type;
  logic [10:0] hdr_len;

  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;

  // Upstream source plus MAC sink side.
  modport master (
    output hdr_valid, hdr_dst, hdr_src, hdr_type, hdr_len, pl_data, pl_valid, out_ready,
    input  hdr_ready, pl_ready, out_data, out_valid, out_sop, out_eop, out_empty
  );

  // The framer itself.
  modport slave (
    input  hdr_valid, hdr_dst, hdr_src, hdr_type, hdr_len, pl_data, pl_valid, out_ready,
    output hdr_ready, pl_ready, out_data, out_valid, out_sop, out_eop, out_empty
  );
endinterface

// File: rtl/avst_byte_packer.sv
// Packs a byte stream into big-endian 32-bit beats with eop/empty.
// A staging word collects bytes; a completed word moves to the output
// register when that register is empty or being drained this cycle.
module avst_byte_packer
  import eth_frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_eop,
  output logic [1:0]  out_empty,
  input  logic        out_ready
);

  logic [31:0] stg_data, stg_data_nx;
  logic [2:0]  stg_cnt, stg_cnt_nx;
  logic        stg_last, stg_last_nx;
  logic        stg_full, move;

  assign stg_full = (stg_cnt == 3'd4) || stg_last;
  assign move     = stg_full && (!out_valid || out_ready);
  // Accepting while the full word moves out keeps 1 byte/cycle.
  assign in_ready = !stg_full || move;

  // Next staging word: cleared on move (zero-fills a short last beat), then byte written.
  always_comb begin
    stg_data_nx = move ? '0 : stg_data;
    stg_cnt_nx  = move ? '0 : stg_cnt;
    stg_last_nx = move ? 1'b0 : stg_last;
    if (in_valid && in_ready) begin
      case (stg_cnt_nx[1:0])
        2'd0:    stg_data_nx[31:24] = in_data;
        2'd1:    stg_data_nx[23:16] = in_data;
        2'd2:    stg_data_nx[15:8]  = in_data;
        default: stg_data_nx[7:0]   = in_data;
      endcase
      stg_cnt_nx  = stg_cnt_nx + 3'd1;
      stg_last_nx = in_last;
    end
  end

  // Staging register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_data <= '0;
      stg_cnt  <= '0;
      stg_last <= 1'b0;
    end else begin
      stg_data <= stg_data_nx;
      stg_cnt  <= stg_cnt_nx;
      stg_last <= stg_last_nx;
    end
  end

  // Output register: holds its beat until out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (move) begin
      out_valid <= 1'b1;
      out_data  <= stg_data;
      out_eop   <= stg_last;
      out_empty <= stg_last ? beat_empty(stg_cnt) : 2'd0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame builder in front of the MAC transmit Avalon-ST sink.
// Beats 0..2 (dst/src) come straight from the latched descriptor; the
// ethertype, payload and pad bytes go through the byte packer.
module eth_frame_tx
  import eth_frame_tx_pkg::*;
#(
  parameter int         MIN_FRAME   = ETH_MIN_FRAME,
  parameter int         MAX_PAYLOAD = ETH_MAX_PAYLOAD,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic         sys_clk,
  input  logic         reset,
  eth_frame_tx_if.slave bus,
  output logic         busy,
  output logic         err_oversize,
  output logic [15:0]  frames_sent
);

  localparam int MIN_PAY = MIN_FRAME - ETH_HDR_BYTES;

  tx_state_t   state, state_nx;
  mac_addr_t   dst_q, src_q;
  logic [15:0] type_q;
  logic [10:0] len_q, pk_total_q, fed_q;
  logic [1:0]  beat_q;
  logic        err_q;
  logic [15:0] frames_q;

  logic        pk_in_valid, pk_in_ready, pk_in_last, pk_take;
  logic [7:0]  pk_in_data;
  logic        pk_out_valid, pk_out_ready, pk_out_eop;
  logic [31:0] pk_out_data;
  logic [1:0]  pk_out_empty;
  logic        accept, oversize, last_byte;

  assign bus.hdr_ready = (state == IDLE) && !reset;
  assign accept        = bus.hdr_valid && bus.hdr_ready;
  assign oversize      = bus.hdr_len > 11'(MAX_PAYLOAD);
  // fed_q counts packer bytes, starting at the ethertype.
  assign last_byte     = fed_q == (pk_total_q - 11'd1);
  assign pk_take       = pk_in_valid && pk_in_ready;
  assign pk_out_ready  = bus.out_ready && (state != HDR);
  assign busy          = state != IDLE;
  assign err_oversize  = err_q;
  assign frames_sent   = frames_q;

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and packer byte source (ethertype, payload or pad).
  always_comb begin
    state_nx     = state;
    pk_in_valid  = 1'b0;
    pk_in_data   = PAD_BYTE;
    pk_in_last   = last_byte;
    bus.pl_ready = 1'b0;
    case (state)
      IDLE: if (accept && !oversize) state_nx = HDR;
      HDR: begin
        if (fed_q < 11'd2) begin
          pk_in_valid = 1'b1;
          pk_in_data  = fed_q[0] ? type_q[7:0] : type_q[15:8];
        end
        if (bus.out_ready && beat_q == 2'd2) state_nx = (len_q == '0) ? PAD : PAY;
      end
      PAY: begin
        pk_in_valid  = bus.pl_valid;
        pk_in_data   = bus.pl_data;
        bus.pl_ready = pk_in_ready;
        if (bus.pl_valid && pk_in_ready && fed_q == len_q + 11'd1)
          state_nx = (len_q < 11'(MIN_PAY)) ? PAD : LAST;
      end
      PAD: begin
        pk_in_valid = 1'b1;
        if (pk_in_ready && last_byte) state_nx = LAST;
      end
      LAST: if (pk_out_valid && bus.out_ready && pk_out_eop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Descriptor latch, beat/byte counters, error pulse and frame counter.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dst_q      <= '0;
      src_q      <= '0;
      type_q     <= '0;
      len_q      <= '0;
      pk_total_q <= '0;
      fed_q      <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      frames_q   <= '0;
    end else begin
      err_q <= accept && oversize;
      if (accept && !oversize) begin
        dst_q      <= bus.hdr_dst;
        src_q      <= bus.hdr_src;
        type_q     <= bus.hdr_type;
        len_q      <= bus.hdr_len;
        pk_total_q <= 11'd2 + ((bus.hdr_len < 11'(MIN_PAY)) ? 11'(MIN_PAY) : bus.hdr_len);
        fed_q      <= '0;
        beat_q     <= '0;
      end else begin
        if (state == HDR && bus.out_ready) beat_q <= beat_q + 2'd1;
        if (pk_take) fed_q <= fed_q + 11'd1;
      end
      if (state == LAST && state_nx == IDLE) frames_q <= frames_q + 16'd1;
    end
  end

  // Output mux: MAC-address beats while in HDR, packer beats otherwise.
  always_comb begin
    bus.out_valid = pk_out_valid;
    bus.out_data  = pk_out_data;
    bus.out_sop   = 1'b0;
    bus.out_eop   = pk_out_eop;
    bus.out_empty = pk_out_empty;
    if (state == HDR) begin
      bus.out_valid = 1'b1;
      bus.out_sop   = (beat_q == 2'd0);
      bus.out_eop   = 1'b0;
      bus.out_empty = 2'd0;
      case (beat_q)
        2'd0:    bus.out_data = dst_q[47:16];
        2'd1:    bus.out_data = {dst_q[15:0], src_q[47:32]};
        default: bus.out_data = src_q[31:0];
      endcase
    end
  end

  avst_byte_packer u_packer (
    .clk       (sys_clk),
    .rst       (reset),
    .in_valid  (pk_in_valid),
    .in_data   (pk_in_data),
    .in_last   (pk_in_last),
    .in_ready  (pk_in_ready),
    .out_valid (pk_out_valid),
    .out_data  (pk_out_data),
    .out_eop   (pk_out_eop),
    .out_empty (pk_out_empty),
    .out_ready (pk_out_ready)
  );

endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: byte-level frame model, per-beat scoreboard,
// hold-until-ready check, directed descriptors and a mid-frame reset.
module tb_eth_frame_tx;
  import eth_frame_tx_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
  } beat_t;

  localparam logic [47:0] DST = 48'h0011_2233_4455;
  localparam logic [47:0] SRC = 48'h02AA_BBCC_DDEE;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        busy, err_oversize;
  logic [15:0] frames_sent;

  eth_frame_tx_if bus();

  eth_frame_tx dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .err_oversize (err_oversize),
    .frames_sent  (frames_sent)
  );

  always #5 sys_clk = ~sys_clk;

  int    tests_run = 0, tests_failed = 0;
  beat_t exp_q[$];
  logic [7:0] pl_q[$];
  bit    rdy_rand = 0, pl_gaps = 0, pl_took = 0, frame_open = 0, hold = 0;
  beat_t held, cur, e;
  int    pops = 0, beat_no = 0, err_cnt = 0, hr_viol = 0, exp_frames = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: whole frame as bytes, then sliced into 4-byte beats.
  task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                       input int len, input int base);
    logic [7:0]  b[$];
    logic [31:0] w;
    int n, nb;
    for (int i = 0; i < 6; i++) b.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(s[47-8*i -: 8]);
    b.push_back(t[15:8]);
    b.push_back(t[7:0]);
    for (int i = 0; i < len; i++) begin
      b.push_back(8'(base + i));
      pl_q.push_back(8'(base + i));
    end
    while (b.size() < 60) b.push_back(8'h00);
    n  = b.size();
    nb = (n + 3) / 4;
    for (int k = 0; k < nb; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w = {w[23:0], (4*k+j < n) ? b[4*k+j] : 8'h00};
      exp_q.push_back('{d: w, sop: (k == 0), eop: (k == nb-1),
                        emp: (k == nb-1) ? 2'((4 - n % 4) % 4) : 2'd0});
    end
  endtask

  // Payload source and MAC ready; both change just after the rising edge.
  always begin
    if (pl_took && pl_q.size() > 0) pl_q.delete(0);
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pl_q.size() > 0 && !(pl_gaps && $urandom_range(0, 2) == 0)) begin
      bus.pl_valid = 1'b1;
      bus.pl_data  = pl_q[0];
    end else begin
      bus.pl_valid = 1'b0;
      bus.pl_data  = 8'h00;
    end
    @(posedge sys_clk); #1;
  end

  always @(negedge sys_clk) pl_took = bus.pl_valid && bus.pl_ready && !reset;

  // Compare process: every transferred beat against the model, plus hold stability.
  always @(negedge sys_clk) begin
    if (reset) begin
      hold    = 0;
      beat_no = 0;
    end else begin
      cur = '{d: bus.out_data, sop: bus.out_sop, eop: bus.out_eop, emp: bus.out_empty};
      if (err_oversize) err_cnt++;
      if (frame_open && bus.hdr_ready) hr_viol++;
      if (hold) chk("stable", {bus.out_valid, cur}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL extra_beat: got %0h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", beat_no), cur, e);
          pops++;
          beat_no++;
          if (e.eop) begin
            beat_no    = 0;
            frame_open = 0;
          end
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                          input logic [10:0] len);
    int n = 0;
    @(posedge sys_clk); #1;
    bus.hdr_dst   = d;
    bus.hdr_src   = s;
    bus.hdr_type  = t;
    bus.hdr_len   = len;
    bus.hdr_valid = 1'b1;
    @(negedge sys_clk);
    while (!bus.hdr_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("hdr_accept", bus.hdr_ready, 1);
    @(posedge sys_clk); #1;
    bus.hdr_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge sys_clk); #1;
      n++;
    end while ((exp_q.size() > 0 || busy) && n < 6000);
    chk({nm, "_done"}, (exp_q.size() == 0 && !busy), 1);
    exp_frames++;
    chk({nm, "_frames"}, frames_sent, exp_frames);
    chk({nm, "_pl_left"}, pl_q.size(), 0);
    chk({nm, "_hdr_ready"}, bus.hdr_ready, 1);
  endtask

  initial begin
    int p0, n;
    logic bad;
    bus.hdr_valid = 1'b0;
    bus.hdr_dst   = '0;
    bus.hdr_src   = '0;
    bus.hdr_type  = '0;
    bus.hdr_len   = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_state", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_empty,
                      bus.hdr_ready, bus.pl_ready, busy, err_oversize, frames_sent}, 0);
    reset = 1'b0;
    @(negedge sys_clk);
    chk("rst_release_hdr_ready", bus.hdr_ready, 1);

    // 1: zero payload, all pad
    build(DST, SRC, 16'h0800, 0, 0);
    chk("m1_beats", exp_q.size(), 15);
    chk("m1_beat0", exp_q[0],  {32'h0011_2233, 1'b1, 1'b0, 2'd0});
    chk("m1_beat1", exp_q[1],  {32'h4455_02AA, 1'b0, 1'b0, 2'd0});
    chk("m1_beat3", exp_q[3],  {32'h0800_0000, 1'b0, 1'b0, 2'd0});
    chk("m1_eop",   exp_q[14], {32'h0000_0000, 1'b0, 1'b1, 2'd0});
    send_hdr(DST, SRC, 16'h0800, 11'd0);
    frame_open = 1;
    wait_done("t1");

    // 2: 47 bytes, T=61, no pad
    build(DST, SRC, 16'h88B5, 47, 1);
    chk("m2_beats", exp_q.size(), 16);
    chk("m2_eop", exp_q[15], {32'h2F00_0000, 1'b0, 1'b1, 2'd3});
    send_hdr(DST, SRC, 16'h88B5, 11'd47);
    frame_open = 1;
    wait_done("t2");

    // 3: maximum payload
    build(SRC, DST, 16'h86DD, 1500, 16);
    chk("m3_beats", exp_q.size(), 379);
    chk("m3_empty", exp_q[378].emp, 2);
    send_hdr(SRC, DST, 16'h86DD, 11'd1500);
    frame_open = 1;
    wait_done("t3");

    // 4: oversize descriptor rejected
    send_hdr(DST, SRC, 16'h0800, 11'd1501);
    @(negedge sys_clk);
    chk("t4_err_pulse", err_oversize, 1);
    @(negedge sys_clk);
    chk("t4_err_clear", err_oversize, 0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      bad |= bus.out_valid | bus.pl_ready | busy;
    end
    chk("t4_idle", bad, 0);
    chk("t4_frames", frames_sent, exp_frames);

    // 5: backpressure and payload gaps
    rdy_rand = 1;
    pl_gaps  = 1;
    build(DST, SRC, 16'h0806, 10, 8'hA0);
    chk("m5_beats", exp_q.size(), 15);
    send_hdr(DST, SRC, 16'h0806, 11'd10);
    frame_open = 1;
    wait_done("t5");
    rdy_rand = 0;
    pl_gaps  = 0;

    // 6: reset during beat 5 of a long frame, then a clean frame
    p0 = pops;
    build(DST, SRC, 16'h0800, 1500, 3);
    send_hdr(DST, SRC, 16'h0800, 11'd1500);
    frame_open = 1;
    n = 0;
    while (pops < p0 + 5 && n < 200) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk("t6_reach_beat5", pops - p0, 5);
    @(posedge sys_clk); #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_empty,
                           bus.hdr_ready, bus.pl_ready, busy, err_oversize, frames_sent}, 0);
    exp_q.delete();
    pl_q.delete();
    frame_open = 0;
    exp_frames = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    reset = 1'b0;
    @(negedge sys_clk);
    chk("t6_after_rst", {bus.hdr_ready, frames_sent}, {1'b1, 16'h0000});
    build(DST, SRC, 16'h0800, 20, 8'h55);
    send_hdr(DST, SRC, 16'h0800, 11'd20);
    frame_open = 1;
    wait_done("t6b");

    chk("err_pulses", err_cnt, 1);
    chk("hdr_ready_in_frame", hr_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
